l2_norm_core: RTL and testbench
===============================

Name: l2_norm_core

Overview:
Streaming L2-norm engine for packets of small signed integer vectors.
- Each accepted input beat carries LANES elements. Each element is squared, the squares are summed across lanes, and the sum is added to a running accumulator.
- On the beat marked last, the accumulated sum of squares goes to an iterative Newton integer square root.
- The root is returned as a single-beat result in unsigned Q24.8 format.
- Sits between the vector DMA stream and the result stream.

Parameters:
LANES, 8, elements per input beat
ELEM_W, 8, element width in bits; elements are signed two's complement
ACC_W, 32, accumulator and square-root input width

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous, active-low reset
in_data  input  LANES*ELEM_W  packed elements; lane i is bits [i*ELEM_W +: ELEM_W]
in_keep  input  LANES  per-lane valid; a lane with keep=0 contributes 0
in_valid  input  1  input beat valid
in_last  input  1  final beat of the vector
in_ready  output  1  core can accept a beat
out_data  output  32  norm, unsigned Q24.8
out_valid  output  1  result valid
out_last  output  1  equals out_valid (every result is a one-beat packet)
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset values (rstn low, asynchronous): in_ready=0 while rstn is low; out_valid=0, out_last=0, out_data=0; accumulator=0; sqrt engine idle.
- States: ACCUM, SQRT, HOLD.
- ACCUM:
  - in_ready=1.
  - A beat transfers when in_valid && in_ready.
  - beat_sum = sum over lanes of (keep ? elem*elem : 0). Each square is unsigned 2*ELEM_W bits; beat_sum is zero-extended to ACC_W.
  - Accumulator update: acc <= acc + beat_sum, modulo 2^ACC_W. Wrap is silent.
  - Squaring and lane summation are purely combinational.
- Transfer with in_last=1:
  - The root operand is acc + beat_sum, i.e. the last beat is included.
  - acc clears to 0 on the same edge.
  - State moves to SQRT.
- SQRT:
  - in_ready=0.
  - Result r = floor(sqrt(N)), exact for every N in 0..2^32-1.
  - Method: Newton iteration x <- (x + N/x)/2 using a sequential restoring divider. Start from x = 2^ceil(bitlen(N)/2). Stop when the new x >= the old x; the result is the old x.
  - N=0 returns 0 in 1 cycle.
  - Worst-case latency from last-beat acceptance to out_valid: at most 1200 cycles.
  - Then out_data <= {8'b0, r[15:0], 8'h00} and state moves to HOLD.
- HOLD:
  - out_valid=1; out_data stays stable until out_ready is high.
  - On out_valid && out_ready: out_valid drops on the next edge and state returns to ACCUM, so in_ready=1 on the following cycle.
  - in_ready=0 throughout HOLD; no input beat is ever dropped or merged.
- Single-beat packet (in_last on the first beat) is legal.
- in_valid during SQRT/HOLD is simply stalled.
- rstn assertion mid-packet or mid-sqrt aborts everything and returns to reset values; a pending result is lost.
- in_keep all zero on a last beat is legal; that beat contributes 0.

Optional Feature:
FRAC_SQRT_EN:
- Defined: the root operand is N<<16 (48 bits). The engine returns floor(sqrt(N*65536)), a 24-bit value giving 8 true fractional bits, and out_data = {8'b0, that value}. Latency bound rises to 2000 cycles.
- Undefined: the fractional byte is always 0x00 as specified above.

Test Plan:
- One beat, lanes {3,4,0,0,0,0,0,0}, keep=0xFF, last=1 -> out_data=0x00000500, out_last=1.
- One beat, lanes {-3,-4,0,...}: 0xFD,0xFC -> out_data=0x00000500. Same beat with keep=0x01 -> 0x00000300.
- Two beats, all lanes 0x7F, last on beat 2: sum 258064 -> out_data=0x0001FC00. A following vector {3,4,0,...} -> 0x00000500, confirming acc cleared.
- All-zero vector -> out_data=0x00000000.
- Edge operands: sum 72 -> 0x00000800 (floor 8). Sum 0xFFFFFFFF via direct accumulator preload or wrap -> root 65535 -> 0x00FFFF00.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, a stalled in_valid beat is not consumed. Release -> 1-cycle transfer, then in_ready=1.
- Reset: deassert rstn mid-SQRT -> out_valid=0 immediately and no result. With FRAC_SQRT_EN, lanes {1,1,0,...} -> out_data=0x0000016A; without it -> 0x00000100.

Source files
------------

// File: rtl/l2_norm_core_if.sv
// rtl/l2_norm_core_if.sv - vector input stream and norm result stream for l2_norm_core
interface l2_norm_core_if #(
    parameter int LANES  = 8,
    parameter int ELEM_W = 8
);
    logic [LANES*ELEM_W-1:0] in_data;
    logic [LANES-1:0]        in_keep;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [31:0]             out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;

    modport master (
        output in_data, in_keep, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_keep, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/l2_norm_core.sv
// rtl/l2_norm_core.sv - streaming sum-of-squares with Newton integer sqrt, Q24.8 result (option: FRAC_SQRT_EN)
module l2_norm_core #(
    parameter int LANES  = 8,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    l2_norm_core_if.slave    s
);
`ifdef FRAC_SQRT_EN
    localparam int SW = ACC_W + 16;
`else
    localparam int SW = ACC_W;
`endif
    localparam int CNT_W = $clog2(SW + 1);

    typedef enum logic [1:0] {ACCUM, SQRT, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] beat_sum;
    logic [ACC_W-1:0] acc_next;
    logic [SW-1:0]    sq_n_next;
    logic [SW-1:0]    sq_n;
    logic [SW-1:0]    sq_x;
    logic [SW-1:0]    x0;
    logic [SW-1:0]    new_x;
    logic [SW-1:0]    div_q;
    logic [SW-1:0]    div_rem;
    logic [SW:0]      rem_sh;
    logic             rem_ge;
    logic [CNT_W-1:0] div_cnt;
    logic             sq_init;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [31:0]      out_data_r;
    logic [31:0]      root_fmt;

    function automatic logic [2*ELEM_W-1:0] square(input logic [ELEM_W-1:0] v);
        logic signed [2*ELEM_W-1:0] e;
        e = {{ELEM_W{v[ELEM_W-1]}}, v};
        return e * e;
    endfunction

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s.in_keep[i])
                beat_sum = beat_sum + {{(ACC_W-2*ELEM_W){1'b0}}, square(s.in_data[i*ELEM_W +: ELEM_W])};
        end
    end

    assign acc_next = acc + beat_sum;

`ifdef FRAC_SQRT_EN
    assign sq_n_next = {acc_next, 16'h0000};
    assign root_fmt  = {8'h00, sq_x[23:0]};
`else
    assign sq_n_next = acc_next;
    assign root_fmt  = {8'h00, sq_x[15:0], 8'h00};
`endif

    // Seed 2^ceil(bitlen/2) is always >= sqrt(N), so Newton descends monotonically.
    always_comb begin
        int unsigned blen;
        blen = 0;
        for (int i = 0; i < SW; i++) begin
            if (sq_n[i])
                blen = i + 1;
        end
        x0 = SW'(1) << ((blen + 1) / 2);
    end

    assign rem_sh = {div_rem, div_q[SW-1]};
    assign rem_ge = rem_sh >= {1'b0, sq_x};
    assign new_x  = SW'(({1'b0, sq_x} + {1'b0, div_q}) >> 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ACCUM;
            acc         <= '0;
            sq_n        <= '0;
            sq_x        <= '0;
            div_q       <= '0;
            div_rem     <= '0;
            div_cnt     <= '0;
            sq_init     <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready_r <= 1'b1;
                    if (s.in_valid && in_ready_r) begin
                        if (s.in_last) begin
                            sq_n       <= sq_n_next;
                            acc        <= '0;
                            sq_init    <= 1'b1;
                            in_ready_r <= 1'b0;
                            state      <= SQRT;
                        end else begin
                            acc <= acc_next;
                        end
                    end
                end
                SQRT: begin
                    if (sq_init) begin
                        sq_init <= 1'b0;
                        if (sq_n == '0) begin
                            out_data_r  <= '0;
                            out_valid_r <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            sq_x    <= x0;
                            div_q   <= sq_n;
                            div_rem <= '0;
                            div_cnt <= CNT_W'(SW);
                        end
                    end else if (div_cnt != '0) begin
                        // One restoring-division step: quotient bits shift in as dividend bits shift out.
                        div_rem <= rem_ge ? SW'(rem_sh - {1'b0, sq_x}) : rem_sh[SW-1:0];
                        div_q   <= {div_q[SW-2:0], rem_ge};
                        div_cnt <= div_cnt - 1'b1;
                    end else if (new_x >= sq_x) begin
                        out_data_r  <= root_fmt;
                        out_valid_r <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        sq_x    <= new_x;
                        div_q   <= sq_n;
                        div_rem <= '0;
                        div_cnt <= CNT_W'(SW);
                    end
                end
                HOLD: begin
                    if (s.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign s.in_ready  = in_ready_r;
    assign s.out_valid = out_valid_r;
    assign s.out_last  = out_valid_r;
    assign s.out_data  = out_data_r;
endmodule

// File: tb/tb_l2_norm_core.sv
// tb/tb_l2_norm_core.sv - directed self-checking bench for l2_norm_core
module tb_l2_norm_core;
    logic clk = 1'b0;
    logic rstn;
    int   passed = 0;
    int   total  = 0;
    int   lat;
    int   seen;

`ifdef FRAC_SQRT_EN
    localparam logic [31:0] E_11  = 32'h0000016A;
    localparam logic [31:0] E_72  = 32'h0000087C;
    localparam logic [31:0] E_MAX = 32'h00FFFFFF;
    localparam int          LAT_MAX = 2000;
`else
    localparam logic [31:0] E_11  = 32'h00000100;
    localparam logic [31:0] E_72  = 32'h00000800;
    localparam logic [31:0] E_MAX = 32'h00FFFF00;
    localparam int          LAT_MAX = 1200;
`endif

    l2_norm_core_if #(.LANES(8), .ELEM_W(8)) bus ();

    l2_norm_core #(.LANES(8), .ELEM_W(8), .ACC_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .s    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        bus.in_data  = d;
        bus.in_keep  = k;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("send_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [31:0] exp, input string tag, output int cycles);
        int n;
        n = 0;
        while (!bus.out_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        cycles = n;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, bus.out_data, exp);
        check({tag, "_last"}, 32'(bus.out_last), 32'd1);
        @(negedge clk);
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_keep   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        send_beat(64'h0000_0000_0000_0403, 8'hFF, 1'b1);
        wait_result(32'h00000500, "p34", lat);
        send_beat(64'h0000_0000_0000_FCFD, 8'hFF, 1'b1);
        wait_result(32'h00000500, "n34", lat);
        send_beat(64'h0000_0000_0000_FCFD, 8'h01, 1'b1);
        wait_result(32'h00000300, "keep01", lat);

        send_beat(64'h7F7F_7F7F_7F7F_7F7F, 8'hFF, 1'b0);
        send_beat(64'h7F7F_7F7F_7F7F_7F7F, 8'hFF, 1'b1);
        wait_result(32'h0001FC00, "two7f", lat);
        send_beat(64'h0000_0000_0000_0403, 8'hFF, 1'b1);
        wait_result(32'h00000500, "acc_clr", lat);

        send_beat(64'h0, 8'hFF, 1'b1);
        wait_result(32'h00000000, "zero", lat);
        check("zero_lat", 32'(lat <= 3), 32'd1);
        send_beat(64'h0000_0000_0000_0403, 8'h00, 1'b1);
        wait_result(32'h00000000, "keep0", lat);

        send_beat(64'h0000_0000_0000_0606, 8'hFF, 1'b1);
        wait_result(E_72, "s72", lat);

        // 32767 full-scale beats + 130817 + 254 = 2^32-1
        for (int i = 0; i < 32767; i++)
            send_beat(64'h8080_8080_8080_8080, 8'hFF, 1'b0);
        send_beat(64'h7F80_8080_8080_8080, 8'hFF, 1'b0);
        send_beat(64'h0000_0000_0002_050F, 8'hFF, 1'b1);
        wait_result(E_MAX, "max", lat);
        check("max_lat", 32'(lat <= LAT_MAX), 32'd1);

        bus.out_ready = 1'b0;
        send_beat(64'h0000_0000_0000_0403, 8'hFF, 1'b1);
        seen = 0;
        while (!bus.out_valid && seen < 3000) begin
            @(negedge clk);
            seen++;
        end
        bus.in_data  = 64'h0000_0000_0000_0101;
        bus.in_keep  = 8'hFF;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", bus.out_data, 32'h00000500);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(E_11, "stalled", lat);

        send_beat(64'h7F7F_7F7F_7F7F_7F7F, 8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        check("mid_sqrt_valid", 32'(bus.out_valid), 32'd0);
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mid_data", bus.out_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("no_lost_result", 32'(seen), 32'd0);
        send_beat(64'h0000_0000_0000_0403, 8'hFF, 1'b1);
        wait_result(32'h00000500, "post_abort", lat);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
